// File: rtl/wb_axi4_bridge_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces used by wb_axi4_bridge.
//
// wb_if    : classic (non-pipelined) Wishbone bus.
//            slave modport  -> adr, dat_w, sel, we, cyc, stb in; dat_r, ack out
//            master modport -> the mirror image
// axi4_if  : AXI4 bus with all five channels (AW, W, B, AR, R).
//            master modport -> drives AW/W/AR payloads and VALIDs, BREADY, RREADY
//            slave modport  -> the mirror image
// ----------------------------------------------------------------------------

interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic                    ack;

  modport slave  (input  adr, dat_w, sel, we, cyc, stb, output dat_r, ack);
  modport master (output adr, dat_w, sel, we, cyc, stb, input  dat_r, ack);
endinterface

interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  // Write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/wb_axi4_bridge.sv
// ----------------------------------------------------------------------------
// wb_axi4_bridge
//
// Wishbone classic slave to AXI4 master bridge. Each WB cycle becomes exactly
// one single-beat AXI4 read or write; only one transaction is in flight.
//
// Ports:
//   axi_clk   clock for all logic
//   rstn      synchronous active-low reset
//   wb_i      Wishbone slave side (adr, dat_w, dat_r, sel, we, cyc, stb, ack)
//   axi_o     AXI4 master side (AW, W, B, AR, R channels)
//   resp_err  1 when the last completed AXI response was not OKAY;
//             takes its new value in the ACK cycle
// ----------------------------------------------------------------------------

module wb_axi4_bridge #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int WB_ADDRESS_WIDTH   = 32,
  parameter int WB_DATA_WIDTH      = 32
) (
  input  logic    axi_clk,
  input  logic    rstn,
  wb_if.slave     wb_i,
  axi4_if.master  axi_o,
  output logic    resp_err
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI4_DATA_WIDTH / 8));
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    ACK
  } state_t;

  state_t                          state_q, state_d;
  logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [WB_DATA_WIDTH/8-1:0]      sel_q, sel_d;
  logic [WB_DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic                            resp_err_q, resp_err_d;

  // Control state is reset; payload registers are always overwritten before use.
  always_ff @(posedge axi_clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    sel_q   <= sel_d;
    rdata_q <= rdata_d;
  end

  // Next-state logic. The WE bit is captured implicitly by the branch taken
  // out of IDLE. resp_err is loaded on the edge that enters ACK so that the
  // new value is already visible while ACK is high.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    rdata_d    = rdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    resp_err_d = resp_err_q;

    case (state_q)
      IDLE: begin
        if (wb_i.cyc && wb_i.stb) begin
          addr_d  = AXI4_ADDRESS_WIDTH'(wb_i.adr);
          wdata_d = wb_i.dat_w;
          sel_d   = wb_i.sel;
          state_d = wb_i.we ? WR_REQ : RD_ADDR;
        end
      end

      RD_ADDR: begin
        if (axi_o.arready) begin
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        if (axi_o.rvalid) begin
          rdata_d    = axi_o.rdata;
          resp_err_d = (axi_o.rresp != 2'b00);
          state_d    = ACK;
        end
      end

      // Each VALID is gated by its own done flag, so OR-ing READY into the
      // flag only records a handshake that really happened.
      WR_REQ: begin
        aw_done_d = aw_done_q | axi_o.awready;
        w_done_d  = w_done_q  | axi_o.wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end

      WR_RESP: begin
        if (axi_o.bvalid) begin
          resp_err_d = (axi_o.bresp != 2'b00);
          state_d    = ACK;
        end
      end

      // STB is deliberately ignored here so the master's post-ACK cycle
      // cannot start a second transaction.
      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // AXI master outputs
  assign axi_o.arid    = '0;
  assign axi_o.araddr  = addr_q;
  assign axi_o.arlen   = 8'd0;
  assign axi_o.arsize  = AXI_SIZE;
  assign axi_o.arburst = BURST_INCR;
  assign axi_o.arvalid = (state_q == RD_ADDR);
  assign axi_o.rready  = (state_q == RD_DATA);

  assign axi_o.awid    = '0;
  assign axi_o.awaddr  = addr_q;
  assign axi_o.awlen   = 8'd0;
  assign axi_o.awsize  = AXI_SIZE;
  assign axi_o.awburst = BURST_INCR;
  assign axi_o.awvalid = (state_q == WR_REQ) && !aw_done_q;

  assign axi_o.wdata   = wdata_q;
  assign axi_o.wstrb   = sel_q;
  assign axi_o.wlast   = 1'b1;
  assign axi_o.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign axi_o.bready  = (state_q == WR_RESP);

  // Wishbone slave outputs
  assign wb_i.ack   = (state_q == ACK);
  assign wb_i.dat_r = rdata_q;
  assign resp_err   = resp_err_q;

  // Single-beat, ID-0 traffic makes these response fields irrelevant.
  logic unused_axi_fields;
  assign unused_axi_fields = ^{axi_o.bid, axi_o.rid, axi_o.rlast};

endmodule

// File: doc/wb_axi4_bridge.md
Name: wb_axi4_bridge

Overview:
Wishbone-slave to AXI4-master bridge, the reverse-direction companion of the AXI4-to-WB bridge. It accepts single classic Wishbone cycles from a WB master (CPU or DMA on a WB fabric). Each cycle is converted into one single-beat AXI4 read or write transaction toward an AXI4 interconnect. Only one transaction is outstanding at a time. It is non-pipelined and has no bursts.

Parameters:
AXI4_ADDRESS_WIDTH, 32, AXI address width; the WB address is zero-extended or truncated to fit.
AXI4_DATA_WIDTH, 32, AXI data width; must equal WB_DATA_WIDTH.
WB_ADDRESS_WIDTH, 32, WB address width.
WB_DATA_WIDTH, 32, WB data width; the SEL width is WB_DATA_WIDTH/8.

Ports:
axi_clk  input  1  clock for all logic.
rstn  input  1  reset: synchronous, active-low, sampled on posedge axi_clk.
wb_i  wb_if.slave  interface  WB slave side; uses ADR, DAT_W, DAT_R, SEL, WE, CYC, STB, ACK.
axi_o  axi4_if.master  interface  AXI4 master side; uses the AW, W, B, AR and R channels.
resp_err  output  1  high when the last completed AXI response had RRESP or BRESP not equal to 0; updated at ACK.

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE.
  - ARVALID, AWVALID, WVALID, RREADY, BREADY, wb ACK and resp_err are all 0.
  - Data and address registers do not require reset.
- Reset mid-operation aborts immediately: all VALID/READY signals drop in the next cycle and no ACK is issued. This AXI protocol break is accepted; system-level reset is assumed to cover both sides.
- Constant AXI fields:
  - ARLEN=AWLEN=0.
  - ARSIZE=AWSIZE=log2(AXI4_DATA_WIDTH/8).
  - ARBURST=AWBURST=INCR.
  - All IDs 0.
  - WLAST=1 whenever WVALID is high.
- State IDLE:
  - When CYC&STB is sampled high: latch ADR, DAT_W, SEL and WE.
  - If WE=0: go to RD_ADDR. If WE=1: go to WR_REQ.
- State RD_ADDR: ARVALID=1 with the latched address. On ARVALID&ARREADY, go to RD_DATA.
- State RD_DATA: RREADY=1. On RVALID: latch RDATA into DAT_R, latch err=(RRESP!=0), go to ACK.
- State WR_REQ:
  - AWVALID and WVALID are asserted together.
  - WDATA=latched DAT_W; WSTRB=latched SEL.
  - Flags aw_done and w_done track each handshake independently; each VALID drops in the cycle after its own handshake.
  - When both are done (same cycle allowed), clear the flags and go to WR_RESP.
  - WREADY arriving before AWREADY, or the reverse, must both be handled.
- State WR_RESP: BREADY=1. On BVALID: latch err=(BRESP!=0), go to ACK.
- State ACK:
  - wb ACK=1 for exactly one cycle; DAT_R is valid that cycle for reads.
  - resp_err is updated from the latched err.
  - Return to IDLE. STB is not sampled in the ACK state, so the WB master's STB-low cycle after ACK cannot retrigger.
- Minimum latency, all READY/VALID handshakes immediate:
  - Read: STB sampled at edge N, ARVALID in cycle N+1, RREADY in N+2, ACK in N+3.
  - Write: AW/W in N+1, BREADY in N+2, ACK in N+3.
- Wait states of any length on ARREADY, RVALID, AWREADY, WREADY or BVALID stretch the corresponding state.
- If CYC drops while busy: the AXI transaction still completes and ACK pulses once, then the bridge returns to IDLE. No cancellation.
- DAT_R holds its last read value between cycles.

Test Plan:
1. Read, zero-wait slave: WB read ADR=0x1000; AXI returns RDATA=0xDEADBEEF with RRESP=0 -> ARADDR=0x1000 with ARLEN=0; ACK exactly 3 cycles after STB; DAT_R=0xDEADBEEF; resp_err=0.
2. Write with SEL=4'b0110, DAT_W=0x12345678 to 0x2004 -> AWADDR=0x2004, WDATA=0x12345678, WSTRB=0110, WLAST=1; one ACK after BVALID.
3. Write channel skew, AWREADY delayed 5 cycles while WREADY is immediate -> WVALID drops after 1 cycle; AWVALID is held 5 cycles; BREADY only after both handshakes; no duplicate AW or W beat.
4. Error response: read with RRESP=2'b10 -> ACK still issued; resp_err=1. A following write with BRESP=0 -> resp_err=0.
5. Back-to-back: read, then a write asserted on the cycle after ACK; RVALID delayed 7 cycles -> transactions are serialised; the second starts only from IDLE; exactly two ACKs.
6. Reset mid-read, with rstn=0 while ARVALID is waiting on ARREADY -> ARVALID=0 the next cycle; no ACK; a new read after reset completes normally.
